// File: rtl/rr_mux_collector_pkg.sv
// Shared channel indices and FSM encoding for the four-channel round-robin collector.
package rr_mux_collector_pkg;
   localparam int         NUM_CH = 4;
   localparam logic [1:0] CH_A   = 2'd0;
   localparam logic [1:0] CH_B   = 2'd1;
   localparam logic [1:0] CH_C   = 2'd2;
   localparam logic [1:0] CH_D   = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;
endpackage

// File: rtl/rr_mux_collector_pick4.sv
// Combinational round-robin picker: first eligible channel scanning from ptr upward, wrapping 3->0.
module rr_pick4
   import rr_mux_collector_pkg::*;
(
   input  logic [3:0] eligible,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] winner
);

   always_comb begin
      logic       found;
      logic [1:0] idx;
      any    = |eligible;
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = ptr + 2'(i);
         if (!found && eligible[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_collector.sv
// Four-channel round-robin collector: captures one word from the winning requester into a
// registered valid/ready output stage and pulses a one-hot ack to that requester.
module rr_mux_collector
   import rr_mux_collector_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic [DATA_W-1:0] data_c,
   input  logic [DATA_W-1:0] data_d,
   output logic [3:0]        ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_sel
);

   state_t            state, state_nxt;
   logic [1:0]        rr_ptr;
   logic [3:0]        eligible;
   logic              any;
   logic [1:0]        winner;
   logic              capture;
   logic [DATA_W-1:0] word_mux;

   // A channel acked this cycle still has its old word on the bus; mask it for one cycle.
   assign eligible = req & ~ack;

   rr_pick4 u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .any      (any),
      .winner   (winner)
   );

   always_comb begin
      unique case (winner)
         CH_A:    word_mux = data_a;
         CH_B:    word_mux = data_b;
         CH_C:    word_mux = data_c;
         CH_D:    word_mux = data_d;
         default: word_mux = data_a;
      endcase
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               capture   = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (out_ready) begin
               capture   = any;
               state_nxt = any ? FULL : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   assign out_valid = (state == FULL);

   // Output stage: word, source and ack all launch on the capture edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr   <= 2'd0;
         ack      <= 4'b0000;
         out_data <= '0;
         out_sel  <= CH_A;
      end else if (capture) begin
         rr_ptr   <= winner + 2'd1;
         ack      <= 4'b0001 << winner;
         out_data <= word_mux;
         out_sel  <= winner;
      end else begin
         ack      <= 4'b0000;
      end
   end

endmodule

// File: tb/tb_rr_mux_collector.sv
// Directed bench for rr_mux_collector: vector table plus hand-written hold/reset sequences.
module tb_rr_mux_collector;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        req;
   logic [DATA_W-1:0] data_a, data_b, data_c, data_d;
   logic [3:0]        ack;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_sel;

   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic       v;
      logic [7:0] d;
      logic [1:0] s;
      logic [3:0] a;
   } vec_t;

   vec_t tbl[$];

   rr_mux_collector #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .data_a    (data_a),
      .data_b    (data_b),
      .data_c    (data_c),
      .data_d    (data_d),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic v, input logic [7:0] d,
                        input logic [1:0] s, input logic [3:0] a);
      nchk++;
      if (out_valid !== v) begin
         nfail++;
         $display("FAIL %s out_valid: got %b want %b", name, out_valid, v);
      end
      nchk++;
      if (out_data !== d) begin
         nfail++;
         $display("FAIL %s out_data: got %h want %h", name, out_data, d);
      end
      nchk++;
      if (out_sel !== s) begin
         nfail++;
         $display("FAIL %s out_sel: got %b want %b", name, out_sel, s);
      end
      nchk++;
      if (ack !== a) begin
         nfail++;
         $display("FAIL %s ack: got %b want %b", name, ack, a);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] rq, input logic rdy, input logic v,
                      input logic [7:0] d, input logic [1:0] s, input logic [3:0] a);
      vec_t e;
      e.rst = rst; e.req = rq; e.rdy = rdy; e.v = v; e.d = d; e.s = s; e.a = a;
      tbl.push_back(e);
   endtask

   initial begin
      // rst req rdy | valid data sel ack
      add(1, 4'b0000, 0, 0, 8'h00, 2'd0, 4'b0000);
      // all four requesting: strict rotation, one word per cycle
      add(0, 4'b1111, 1, 1, 8'h11, 2'd0, 4'b0001);
      add(0, 4'b1111, 1, 1, 8'h22, 2'd1, 4'b0010);
      add(0, 4'b1111, 1, 1, 8'h33, 2'd2, 4'b0100);
      add(0, 4'b1111, 1, 1, 8'h44, 2'd3, 4'b1000);
      add(0, 4'b1111, 1, 1, 8'h11, 2'd0, 4'b0001);
      // lone B held high: captured every other cycle
      add(0, 4'b0010, 1, 1, 8'h22, 2'd1, 4'b0010);
      add(0, 4'b0010, 1, 0, 8'h22, 2'd1, 4'b0000);
      add(0, 4'b0010, 1, 1, 8'h22, 2'd1, 4'b0010);
      add(0, 4'b0010, 1, 0, 8'h22, 2'd1, 4'b0000);
      add(0, 4'b0010, 1, 1, 8'h22, 2'd1, 4'b0010);
      // C leaves ptr at 3; A,B then wrap 3->0, ptr ends at 2 so C is next
      add(0, 4'b0100, 1, 1, 8'h33, 2'd2, 4'b0100);
      add(0, 4'b0011, 1, 1, 8'h11, 2'd0, 4'b0001);
      add(0, 4'b0011, 1, 1, 8'h22, 2'd1, 4'b0010);
      add(0, 4'b1111, 1, 1, 8'h33, 2'd2, 4'b0100);
      // backpressure holds word; D wins on release
      add(0, 4'b1111, 0, 1, 8'h33, 2'd2, 4'b0000);
      add(0, 4'b1111, 0, 1, 8'h33, 2'd2, 4'b0000);
      add(0, 4'b1111, 1, 1, 8'h44, 2'd3, 4'b1000);
      // reset while FULL under backpressure, then D served first
      add(0, 4'b1111, 0, 1, 8'h44, 2'd3, 4'b0000);
      add(1, 4'b1111, 0, 0, 8'h00, 2'd0, 4'b0000);
      add(0, 4'b1000, 1, 1, 8'h44, 2'd3, 4'b1000);

      reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
      data_a = 8'hA5; data_b = 8'h22; data_c = 8'h33; data_d = 8'h44;
      step();
      check("reset", 1'b0, 8'h00, 2'd0, 4'b0000);

      // single word from A
      reset = 1'b0; req = 4'b0001; out_ready = 1'b1;
      step();
      check("single_a", 1'b1, 8'hA5, 2'd0, 4'b0001);
      req = 4'b0000;
      step();
      check("single_a_done", 1'b0, 8'hA5, 2'd0, 4'b0000);

      // table
      reset = 1'b1; step(); reset = 1'b0;
      data_a = 8'h11;
      foreach (tbl[i]) begin
         reset = tbl[i].rst; req = tbl[i].req; out_ready = tbl[i].rdy;
         step();
         check($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].a);
      end

      // C word held five cycles under backpressure while inputs change
      reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
      step();
      reset = 1'b0; req = 4'b0100; data_c = 8'h3C;
      step();
      check("hold_cap", 1'b1, 8'h3C, 2'd2, 4'b0100);
      req = 4'b1100; data_c = 8'h99;
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("hold%0d", k), 1'b1, 8'h3C, 2'd2, 4'b0000);
      end
      out_ready = 1'b1;
      step();
      check("hold_release", 1'b1, 8'h44, 2'd3, 4'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
